// File: rtl/bayer_mosaic_enc.sv
// bayer_mosaic_enc
//   Re-mosaic encoder. It accepts one RGB pixel per transfer in raster order,
//   tracks the pixel's (x, y) position and keeps only the colour channel that
//   the CFA has at that site. Each output is a single-channel Bayer sample
//   with its coordinates and frame markers.
//   The block has a one-entry output buffer (EMPTY/FULL). A pixel is
//   accepted only while the buffer is EMPTY, so the peak rate is one pixel
//   every two clocks.
//
// Ports
//   clock, reset      single clock; synchronous active-high reset
//   u_i_ready         upstream pixel valid on data_in
//   u_r_ready         upstream status, has no effect
//   u_sof             pixel is the first of a frame (only looked at on accept)
//   data_in           {R, G, B}, PIX_W bits each, R in the MSBs
//   d_i_ready         downstream takes the held sample this cycle
//   data_out          CFA channel selected for the site
//   pixel_type_out    00 R, 01 G, 10 B
//   x_out, y_out      coordinates of data_out
//   sof_out           data_out is pixel (0,0)
//   eol_out           data_out is the last pixel of a line
//   eof_out           data_out is the last pixel of the frame
//   frame_cnt_out     number of completed frames, wraps at 16 bits
//   sync_err_out      sticky: u_sof arrived while the counters were not at (0,0)
//   i_i_ready         block can accept a pixel (EMPTY)
//   i_r_ready         data_out and its markers are valid (FULL)

module bayer_mosaic_enc #(
    parameter int         PIX_W = 24,
    parameter int         IMG_W = 4096,
    parameter int         IMG_H = 3072,
    parameter logic [1:0] CFA   = 2'b00
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 u_i_ready,
    input  logic                 u_r_ready,
    input  logic                 u_sof,
    input  logic [3*PIX_W-1:0]   data_in,
    input  logic                 d_i_ready,
    output logic [PIX_W-1:0]     data_out,
    output logic [1:0]           pixel_type_out,
    output logic [11:0]          x_out,
    output logic [11:0]          y_out,
    output logic                 sof_out,
    output logic                 eol_out,
    output logic                 eof_out,
    output logic [15:0]          frame_cnt_out,
    output logic                 sync_err_out,
    output logic                 i_i_ready,
    output logic                 i_r_ready
);

    // state   | meaning
    // S_EMPTY | output buffer free, a pixel may be accepted
    // S_FULL  | sample held on the outputs until downstream takes it
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [11:0] X_MAX = 12'(IMG_W - 1);
    localparam logic [11:0] Y_MAX = 12'(IMG_H - 1);

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_G = 2'b01;
    localparam logic [1:0] TYPE_B = 2'b10;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [11:0]       r_x;
    logic [11:0]       r_y;
    logic [15:0]       r_frame_cnt;
    logic              r_sync_err;

    logic [PIX_W-1:0]  r_data;
    logic [1:0]        r_type;
    logic [11:0]       r_x_o;
    logic [11:0]       r_y_o;
    logic              r_sof;
    logic              r_eol;
    logic              r_eof;

    logic              w_accept;
    logic [11:0]       w_tag_x;
    logic [11:0]       w_tag_y;
    logic [1:0]        w_phase;
    logic [PIX_W-1:0]  w_sample;
    logic [1:0]        w_type;
    logic              w_at_eol;
    logic              w_at_eof;
    logic [11:0]       w_x_nxt;
    logic [11:0]       w_y_nxt;
    logic              w_unused;

    assign w_unused = u_r_ready;

    assign w_accept = u_i_ready && (r_state == S_EMPTY);

    // A start-of-frame on accept overrides the running position: the pixel
    // becomes (0,0) and counting resumes from there.
    assign w_tag_x  = u_sof ? 12'd0 : r_x;
    assign w_tag_y  = u_sof ? 12'd0 : r_y;
    assign w_phase  = {w_tag_y[0] ^ CFA[1], w_tag_x[0] ^ CFA[0]};
    assign w_at_eol = (w_tag_x == X_MAX);
    assign w_at_eof = w_at_eol && (w_tag_y == Y_MAX);

    always_comb begin
        w_sample = data_in[2*PIX_W-1:PIX_W];
        w_type   = TYPE_G;
        case (w_phase)
            2'b00: begin
                w_sample = data_in[3*PIX_W-1:2*PIX_W];
                w_type   = TYPE_R;
            end
            2'b11: begin
                w_sample = data_in[PIX_W-1:0];
                w_type   = TYPE_B;
            end
            default: begin
                w_sample = data_in[2*PIX_W-1:PIX_W];
                w_type   = TYPE_G;
            end
        endcase
    end

    always_comb begin
        w_x_nxt = w_tag_x + 12'd1;
        w_y_nxt = w_tag_y;
        if (w_at_eol) begin
            w_x_nxt = 12'd0;
            w_y_nxt = w_at_eof ? 12'd0 : (w_tag_y + 12'd1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (u_i_ready) w_state_nxt = S_FULL;
            S_FULL:  if (d_i_ready) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
            r_sync_err  <= 1'b0;
            r_data      <= '0;
            r_type      <= '0;
            r_x_o       <= '0;
            r_y_o       <= '0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data <= w_sample;
                r_type <= w_type;
                r_x_o  <= w_tag_x;
                r_y_o  <= w_tag_y;
                r_sof  <= (w_tag_x == 12'd0) && (w_tag_y == 12'd0);
                r_eol  <= w_at_eol;
                r_eof  <= w_at_eof;
                r_x    <= w_x_nxt;
                r_y    <= w_y_nxt;
                // Only a natural end of frame counts; a resync never does.
                if (w_at_eof) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
                if (u_sof && ((r_x != 12'd0) || (r_y != 12'd0))) begin
                    r_sync_err <= 1'b1;
                end
            end
        end
    end

    assign data_out       = r_data;
    assign pixel_type_out = r_type;
    assign x_out          = r_x_o;
    assign y_out          = r_y_o;
    assign sof_out        = r_sof;
    assign eol_out        = r_eol;
    assign eof_out        = r_eof;
    assign frame_cnt_out  = r_frame_cnt;
    assign sync_err_out   = r_sync_err;
    assign i_i_ready      = (r_state == S_EMPTY);
    assign i_r_ready      = (r_state == S_FULL);

endmodule

// File: tb/tb_bayer_mosaic_enc.sv
// Testbench for bayer_mosaic_enc with IMG_W=4, IMG_H=2, PIX_W=8.
// Instance dut uses CFA=00 (RGGB). Instance dut_b uses CFA=11 (BGGR) and
// shares every input with dut.

module tb_bayer_mosaic_enc;

    localparam int PW = 8;

    logic          clock;
    logic          reset;
    logic          u_i_ready;
    logic          u_r_ready;
    logic          u_sof;
    logic [23:0]   data_in;
    logic          d_i_ready;

    logic [7:0]    data_out;
    logic [1:0]    pixel_type_out;
    logic [11:0]   x_out, y_out;
    logic          sof_out, eol_out, eof_out;
    logic [15:0]   frame_cnt_out;
    logic          sync_err_out, i_i_ready, i_r_ready;

    logic [7:0]    b_data_out;
    logic [1:0]    b_pixel_type_out;
    logic [11:0]   b_x_out, b_y_out;
    logic          b_sof_out, b_eol_out, b_eof_out;
    logic [15:0]   b_frame_cnt_out;
    logic          b_sync_err_out, b_i_i_ready, b_i_r_ready;

    int n_cmp = 0;
    int n_err = 0;

    bayer_mosaic_enc #(.PIX_W(PW), .IMG_W(4), .IMG_H(2), .CFA(2'b00)) dut (
        .clock(clock), .reset(reset), .u_i_ready(u_i_ready), .u_r_ready(u_r_ready),
        .u_sof(u_sof), .data_in(data_in), .d_i_ready(d_i_ready),
        .data_out(data_out), .pixel_type_out(pixel_type_out), .x_out(x_out), .y_out(y_out),
        .sof_out(sof_out), .eol_out(eol_out), .eof_out(eof_out),
        .frame_cnt_out(frame_cnt_out), .sync_err_out(sync_err_out),
        .i_i_ready(i_i_ready), .i_r_ready(i_r_ready)
    );

    bayer_mosaic_enc #(.PIX_W(PW), .IMG_W(4), .IMG_H(2), .CFA(2'b11)) dut_b (
        .clock(clock), .reset(reset), .u_i_ready(u_i_ready), .u_r_ready(u_r_ready),
        .u_sof(u_sof), .data_in(data_in), .d_i_ready(d_i_ready),
        .data_out(b_data_out), .pixel_type_out(b_pixel_type_out), .x_out(b_x_out), .y_out(b_y_out),
        .sof_out(b_sof_out), .eol_out(b_eol_out), .eof_out(b_eof_out),
        .frame_cnt_out(b_frame_cnt_out), .sync_err_out(b_sync_err_out),
        .i_i_ready(b_i_i_ready), .i_r_ready(b_i_r_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  r, g, b;
        logic        sof;
        logic [7:0]  e_data;
        logic [1:0]  e_type;
        logic [11:0] e_x, e_y;
        logic        e_sof, e_eol, e_eof;
        logic [15:0] e_fc;
    } vec_t;

    vec_t vec [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge. Presents a pixel, waits for it to be accepted and
    // returns at the negedge after the accepting edge.
    task automatic accept_pixel(input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b, input logic sof);
        int t = 0;
        u_i_ready = 1'b1;
        data_in   = {r, g, b};
        u_sof     = sof;
        while (!i_i_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("accept_wait", {31'd0, i_i_ready}, 32'd1);
        @(posedge clock);
        #1;
        u_i_ready = 1'b0;
        u_sof     = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_empty();
        int t = 0;
        while (!i_i_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("empty_wait", {31'd0, i_i_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          r     g      b      sof  data   type  x      y      sof eol eof fc
        vec[0] = '{8'd0, 8'd16, 8'd32, 1'b0, 8'd0,  2'd0, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 16'd0};
        vec[1] = '{8'd1, 8'd17, 8'd33, 1'b0, 8'd17, 2'd1, 12'd1, 12'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[2] = '{8'd2, 8'd18, 8'd34, 1'b0, 8'd2,  2'd0, 12'd2, 12'd0, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[3] = '{8'd3, 8'd19, 8'd35, 1'b0, 8'd19, 2'd1, 12'd3, 12'd0, 1'b0, 1'b1, 1'b0, 16'd0};
        vec[4] = '{8'd4, 8'd20, 8'd36, 1'b0, 8'd20, 2'd1, 12'd0, 12'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[5] = '{8'd5, 8'd21, 8'd37, 1'b0, 8'd37, 2'd2, 12'd1, 12'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[6] = '{8'd6, 8'd22, 8'd38, 1'b0, 8'd22, 2'd1, 12'd2, 12'd1, 1'b0, 1'b0, 1'b0, 16'd0};
        vec[7] = '{8'd7, 8'd23, 8'd39, 1'b0, 8'd39, 2'd2, 12'd3, 12'd1, 1'b0, 1'b1, 1'b1, 16'd1};

        reset     = 1'b1;
        u_i_ready = 1'b0;
        u_r_ready = 1'b0;
        u_sof     = 1'b0;
        data_in   = '0;
        d_i_ready = 1'b1;

        // Reset state after holding reset for three cycles.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_data",  {24'd0, data_out}, 32'd0);
        check("rst_type",  {30'd0, pixel_type_out}, 32'd0);
        check("rst_x",     {20'd0, x_out}, 32'd0);
        check("rst_y",     {20'd0, y_out}, 32'd0);
        check("rst_marks", {29'd0, sof_out, eol_out, eof_out}, 32'd0);
        check("rst_fc",    {16'd0, frame_cnt_out}, 32'd0);
        check("rst_serr",  {31'd0, sync_err_out}, 32'd0);
        check("rst_iir",   {31'd0, i_i_ready}, 32'd1);
        check("rst_irr",   {31'd0, i_r_ready}, 32'd0);
        reset = 1'b0;

        // One full RGGB frame with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            accept_pixel(vec[i].r, vec[i].g, vec[i].b, vec[i].sof);
            check($sformatf("v%0d_valid", i), {31'd0, i_r_ready}, 32'd1);
            check($sformatf("v%0d_data", i),  {24'd0, data_out}, {24'd0, vec[i].e_data});
            check($sformatf("v%0d_type", i),  {30'd0, pixel_type_out}, {30'd0, vec[i].e_type});
            check($sformatf("v%0d_x", i),     {20'd0, x_out}, {20'd0, vec[i].e_x});
            check($sformatf("v%0d_y", i),     {20'd0, y_out}, {20'd0, vec[i].e_y});
            check($sformatf("v%0d_sof", i),   {31'd0, sof_out}, {31'd0, vec[i].e_sof});
            check($sformatf("v%0d_eol", i),   {31'd0, eol_out}, {31'd0, vec[i].e_eol});
            check($sformatf("v%0d_eof", i),   {31'd0, eof_out}, {31'd0, vec[i].e_eof});
            check($sformatf("v%0d_fc", i),    {16'd0, frame_cnt_out}, {16'd0, vec[i].e_fc});
        end

        // Back-pressure: hold FULL for five cycles with a second pixel waiting.
        @(negedge clock);
        wait_empty();
        d_i_ready = 1'b0;
        accept_pixel(8'hAA, 8'hBB, 8'hCC, 1'b0);
        u_i_ready = 1'b1;
        data_in   = {8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d_irr", i),  {31'd0, i_r_ready}, 32'd1);
            check($sformatf("bp%0d_iir", i),  {31'd0, i_i_ready}, 32'd0);
            check($sformatf("bp%0d_data", i), {24'd0, data_out}, 32'hAA);
            check($sformatf("bp%0d_x", i),    {20'd0, x_out}, 32'd0);
            check($sformatf("bp%0d_sof", i),  {31'd0, sof_out}, 32'd1);
            @(negedge clock);
        end
        d_i_ready = 1'b1;
        @(negedge clock);
        check("bp_release_iir", {31'd0, i_i_ready}, 32'd1);
        check("bp_release_irr", {31'd0, i_r_ready}, 32'd0);
        @(posedge clock);
        #1;
        u_i_ready = 1'b0;
        @(negedge clock);
        check("bp_next_irr",  {31'd0, i_r_ready}, 32'd1);
        check("bp_next_data", {24'd0, data_out}, 32'h22);
        check("bp_next_x",    {20'd0, x_out}, 32'd1);
        check("bp_next_type", {30'd0, pixel_type_out}, 32'd1);
        check("bp_serr",      {31'd0, sync_err_out}, 32'd0);

        // u_sof on the third pixel of a line: resync to (0,0) and flag error.
        accept_pixel(8'h44, 8'h55, 8'h66, 1'b1);
        check("resync_x",    {20'd0, x_out}, 32'd0);
        check("resync_y",    {20'd0, y_out}, 32'd0);
        check("resync_sof",  {31'd0, sof_out}, 32'd1);
        check("resync_data", {24'd0, data_out}, 32'h44);
        check("resync_serr", {31'd0, sync_err_out}, 32'd1);
        check("resync_fc",   {16'd0, frame_cnt_out}, 32'd1);
        accept_pixel(8'h77, 8'h88, 8'h99, 1'b0);
        check("after_x",     {20'd0, x_out}, 32'd1);
        check("after_y",     {20'd0, y_out}, 32'd0);
        check("after_sof",   {31'd0, sof_out}, 32'd0);
        check("after_data",  {24'd0, data_out}, 32'h88);
        check("after_serr",  {31'd0, sync_err_out}, 32'd1);

        // Reset while FULL drops the held pixel and clears counters.
        wait_empty();
        d_i_ready = 1'b0;
        accept_pixel(8'hD0, 8'hD1, 8'hD2, 1'b0);
        check("pre_rst_irr",  {31'd0, i_r_ready}, 32'd1);
        check("pre_rst_x",    {20'd0, x_out}, 32'd2);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("frst_irr",  {31'd0, i_r_ready}, 32'd0);
        check("frst_iir",  {31'd0, i_i_ready}, 32'd1);
        check("frst_serr", {31'd0, sync_err_out}, 32'd0);
        check("frst_fc",   {16'd0, frame_cnt_out}, 32'd0);
        check("frst_data", {24'd0, data_out}, 32'd0);
        reset     = 1'b0;
        d_i_ready = 1'b1;

        // First pixel after reset: (0,0) on both instances, BGGR selects B.
        accept_pixel(8'd1, 8'd2, 8'd3, 1'b0);
        check("a_x",      {20'd0, x_out}, 32'd0);
        check("a_y",      {20'd0, y_out}, 32'd0);
        check("a_sof",    {31'd0, sof_out}, 32'd1);
        check("a_type",   {30'd0, pixel_type_out}, 32'd0);
        check("a_data",   {24'd0, data_out}, 32'd1);
        check("b_type",   {30'd0, b_pixel_type_out}, 32'd2);
        check("b_data",   {24'd0, b_data_out}, 32'd3);
        check("b_xy",     {8'd0, b_x_out, b_y_out}, 32'd0);
        check("b_marks",  {29'd0, b_sof_out, b_eol_out, b_eof_out}, 32'd4);
        check("b_fc",     {16'd0, b_frame_cnt_out}, 32'd0);
        check("b_serr",   {31'd0, b_sync_err_out}, 32'd0);
        check("b_flags",  {30'd0, b_i_i_ready, b_i_r_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
